// File: rtl/pipe_pkg.sv
// Shared definitions for the issue/hazard controller: instruction format,
// opcodes, FSM states and decode helpers.
package pipe_pkg;
    localparam int NREG    = 8;
    localparam int RIDX_W  = 3;
    localparam int RAW_GAP = 2;
    localparam int CNT_W   = 16;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;

    typedef logic [3:0] opcode_t;
    localparam opcode_t OP_ADD  = 4'b0001;
    localparam opcode_t OP_SUB  = 4'b0010;
    localparam opcode_t OP_LOAD = 4'b0011;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} ctrl_state_t;

    typedef struct packed {
        opcode_t           op;
        logic [RIDX_W-1:0] rd;
        logic [RIDX_W-1:0] rs1;
        logic [RIDX_W-1:0] rs2;
    } decoded_t;

    function automatic decoded_t decode(input logic [15:0] instr);
        decoded_t d;
        d.op  = instr[OP_LSB  +: 4];
        d.rd  = instr[RD_LSB  +: RIDX_W];
        d.rs1 = instr[RS1_LSB +: RIDX_W];
        d.rs2 = instr[RS2_LSB +: RIDX_W];
        return d;
    endfunction

    function automatic logic uses_rs1(input decoded_t d);
        return (d.op == OP_ADD) || (d.op == OP_SUB);
    endfunction

    function automatic logic uses_rs2(input decoded_t d);
        return (d.op == OP_ADD) || (d.op == OP_SUB);
    endfunction

    // R0 is hardwired, so a write to it never creates a dependency.
    function automatic logic writes_rd(input decoded_t d);
        return ((d.op == OP_ADD) || (d.op == OP_SUB) || (d.op == OP_LOAD)) && (d.rd != '0);
    endfunction
endpackage

// File: rtl/pipe_issue_ctrl_if.sv
// ID-stage request and pipeline-control response bundle for pipe_issue_ctrl.
interface pipe_issue_ctrl_if #(parameter int CNT_W = 16);
    logic             id_valid;
    logic [15:0]      id_instr;
    logic             flush;
    logic             halt_req;
    logic             resume;
    logic             issue;
    logic             bubble;
    logic             pc_en;
    logic             ifid_en;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] issue_count;

    modport master (
        output id_valid, id_instr, flush, halt_req, resume,
        input  issue, bubble, pc_en, ifid_en, halted, stall_count, issue_count
    );

    modport slave (
        input  id_valid, id_instr, flush, halt_req, resume,
        output issue, bubble, pc_en, ifid_en, halted, stall_count, issue_count
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// Per-register countdown scoreboard: a register is busy until its producer's
// write-back lands, counted in edges since issue.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREG    = pipe_pkg::NREG,
    parameter int RIDX_W  = pipe_pkg::RIDX_W,
    parameter int RAW_GAP = pipe_pkg::RAW_GAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [RIDX_W-1:0] set_idx,
    input  logic [RIDX_W-1:0] rs1_idx,
    input  logic [RIDX_W-1:0] rs2_idx,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              all_idle
);
    localparam int CW = $clog2(RAW_GAP + 1);

    logic [NREG-1:0][CW-1:0] cnt;
    logic [NREG-1:0]         busy;

    // Entry 0 is never loaded, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (set_en && set_idx == RIDX_W'(i))
                    cnt[i] <= CW'(RAW_GAP);
                else if (cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NREG; i++)
            busy[i] = |cnt[i];
    end

    assign rs1_busy = busy[rs1_idx];
    assign rs2_busy = busy[rs2_idx];
    assign all_idle = ~|busy;
endmodule

// File: rtl/pipe_issue_ctrl.sv
// ID->EX issue controller: stall-on-RAW using the scoreboard, flush handling,
// debug halt/drain/resume FSM and performance counters.
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int NREG    = pipe_pkg::NREG,
    parameter int RIDX_W  = pipe_pkg::RIDX_W,
    parameter int RAW_GAP = pipe_pkg::RAW_GAP,
    parameter int CNT_W   = pipe_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_issue_ctrl_if.slave   bus
);
    ctrl_state_t state_q, state_d;
    decoded_t    dec;
    logic        rs1_busy, rs2_busy, all_idle;
    logic        hazard, run_ok, issue_i, set_en, stall_inc;

    assign dec    = decode(bus.id_instr);
    assign hazard = bus.id_valid & ((uses_rs1(dec) & rs1_busy) | (uses_rs2(dec) & rs2_busy));
    assign run_ok = (state_q == RUN) & ~bus.halt_req;

    // rst_n gates the combinational outputs so the pipe is frozen while held in reset.
    assign issue_i     = rst_n & bus.id_valid & ~hazard & ~bus.flush & run_ok;
    assign bus.issue   = issue_i;
    assign bus.bubble  = ~issue_i;
    assign bus.pc_en   = rst_n & (bus.flush | (run_ok & (issue_i | ~bus.id_valid)));
    assign bus.ifid_en = bus.pc_en;
    assign bus.halted  = (state_q == HALTED);

    assign set_en    = issue_i & writes_rd(dec);
    assign stall_inc = run_ok & bus.id_valid & hazard & ~bus.flush;

    pipe_scoreboard #(
        .NREG    (NREG),
        .RIDX_W  (RIDX_W),
        .RAW_GAP (RAW_GAP)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en),
        .set_idx  (dec.rd),
        .rs1_idx  (dec.rs1),
        .rs2_idx  (dec.rs2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .all_idle (all_idle)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.halt_req)                 state_d = DRAIN;
            DRAIN:   if (all_idle)                     state_d = HALTED;
            HALTED:  if (bus.resume && !bus.halt_req)  state_d = RUN;
            default:                                   state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.stall_count <= '0;
            bus.issue_count <= '0;
        end else begin
            if (stall_inc && !(&bus.stall_count))
                bus.stall_count <= bus.stall_count + 1'b1;
            if (issue_i)
                bus.issue_count <= bus.issue_count + 1'b1;
        end
    end
endmodule
